// File: rtl/decoder_quiz_pkg.sv
// Shared types and constants for the decoder quiz checker: FSM states and LFSR setup.
// The LFSR is Fibonacci x^16+x^14+x^13+x^11+1, right-shifting with feedback into bit 15.
package decoder_quiz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Taps at bits 0,2,3,5 of the right-shifting register realise x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/line_decoder_ref.sv
// Reference line decoder: combinational binary to one-hot, zero latency, no flow control.
module line_decoder_ref #(
  parameter int IN_W = 2,
  localparam int OUT_W = 2**IN_W
) (
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] y
);

  always_comb begin
    y    = '0;
    y[a] = 1'b1;
  end

endmodule

// File: rtl/decoder_quiz_checker.sv
// Drives a decoder under test with NUM_VEC vectors and checks each result LAT cycles later.
// One vector per cycle in RUN; start is ignored while busy, results hold in DONE.
module decoder_quiz_checker
  import decoder_quiz_pkg::*;
#(
  parameter int          IN_W    = 2,
  parameter int          NUM_VEC = 64,
  parameter int          LAT     = 0,
  parameter int          MODE    = 1,
  parameter logic [15:0] SEED    = 16'hACE1,
  localparam int         OUT_W   = 2**IN_W,
  localparam int         CNT_W   = $clog2(NUM_VEC + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  output logic [IN_W-1:0]  a,
  input  logic [OUT_W-1:0] b_test,
  output logic [OUT_W-1:0] b_true,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [IN_W-1:0]  first_err_a,
  output logic             first_err_vld
);

  localparam logic [15:0]      SEED_EFF   = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
  localparam int               PD         = (LAT == 0) ? 1 : LAT;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] LAST_VEC   = CNT_W'(NUM_VEC - 1);
  localparam logic [1:0]       LAST_DRAIN = 2'(PD - 1);

  state_t           state;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] vec_cnt;
  logic [1:0]       drain_cnt;
  logic [IN_W-1:0]  pipe_a [PD];
  logic [PD-1:0]    pipe_vld;

  logic [IN_W-1:0]  tail_a;
  logic             tail_vld;
  logic [15:0]      lfsr_nxt;
  logic [IN_W-1:0]  next_a;
  logic [IN_W-1:0]  first_vec;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt_nxt;

  // The pipeline carries the stimulus itself; the reference decode is applied at its tail,
  // so b_true and the compare always see the same delayed vector.
  always_comb begin
    tail_a   = a;
    tail_vld = 1'b0;
    if (LAT == 0) begin
      tail_a   = a;
      tail_vld = (state == ST_RUN);
    end else begin
      tail_a   = pipe_a[PD-1];
      tail_vld = pipe_vld[PD-1] && (state == ST_RUN || state == ST_DRAIN);
    end
  end

  line_decoder_ref #(.IN_W(IN_W)) u_ref (
    .a (tail_a),
    .y (b_true)
  );

  always_comb begin
    lfsr_nxt  = lfsr_step(lfsr);
    next_a    = (MODE == 0) ? a + 1'b1 : lfsr_nxt[IN_W-1:0];
    first_vec = (MODE == 0) ? '0 : SEED_EFF[IN_W-1:0];
    mismatch  = tail_vld && (b_test != b_true);
    err_cnt_nxt = err_cnt;
    if (mismatch && err_cnt != CNT_MAX) begin
      err_cnt_nxt = err_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      a             <= '0;
      lfsr          <= SEED_EFF;
      vec_cnt       <= '0;
      drain_cnt     <= '0;
      err_cnt       <= '0;
      first_err_a   <= '0;
      first_err_vld <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      pipe_vld      <= '0;
      for (int i = 0; i < PD; i++) begin
        pipe_a[i] <= '0;
      end
    end else begin
      pipe_a[0]   <= a;
      pipe_vld[0] <= (state == ST_RUN);
      for (int i = 1; i < PD; i++) begin
        pipe_a[i]   <= pipe_a[i-1];
        pipe_vld[i] <= pipe_vld[i-1];
      end

      if (mismatch) begin
        err_cnt <= err_cnt_nxt;
        if (!first_err_vld) begin
          first_err_a   <= tail_a;
          first_err_vld <= 1'b1;
        end
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_RUN;
            a             <= first_vec;
            lfsr          <= SEED_EFF;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
          end
        end
        ST_RUN: begin
          if (vec_cnt == LAST_VEC) begin
            // a keeps the last vector; with no latency the final compare lands on this edge.
            if (LAT == 0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_cnt_nxt == '0);
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            a       <= next_a;
            lfsr    <= lfsr_nxt;
            vec_cnt <= vec_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt_nxt == '0);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_quiz_checker.sv
// Directed bench: four checker instances covering pass/fail runs, latency, drain, reset and saturation.
module tb_decoder_quiz_checker;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // u0: IN_W=2 LAT=0 MODE=0 NUM_VEC=8, decoder with selectable faults
  logic       start0 = 1'b0;
  logic [1:0] a0, first_a0;
  logic [3:0] b_test0, b_true0, err0;
  logic       busy0, done0, pass0, vld0;
  int         fault_sel = 0;

  // u1: IN_W=3 LAT=2 MODE=1 NUM_VEC=8, two-stage registered correct decoder
  logic       start1 = 1'b0;
  logic [2:0] a1, first_a1;
  logic [7:0] b_test1, b_true1, r1a;
  logic [3:0] err1;
  logic       busy1, done1, pass1, vld1;

  // u2: IN_W=3 LAT=1 MODE=0 NUM_VEC=8, same two-stage decoder (latency mismatch)
  logic       start2 = 1'b0;
  logic [2:0] a2, first_a2;
  logic [7:0] b_test2, b_true2, r2a;
  logic [3:0] err2;
  logic       busy2, done2, pass2, vld2;

  // u3: IN_W=2 LAT=0 MODE=0 NUM_VEC=3, decoder stuck at zero
  logic       start3 = 1'b0;
  logic [1:0] a3, first_a3;
  logic [3:0] b_true3;
  logic [3:0] b_test3 = 4'b0000;
  logic [1:0] err3;
  logic       busy3, done3, pass3, vld3;

  always_comb begin
    b_test0 = 4'd1 << a0;
    case (fault_sel)
      1: if (a0 == 2'd2) b_test0 = 4'b0000;
      2: b_test0 = 4'b0000;
      3: if (a0 == 2'd3) b_test0 = 4'b1001;
      4: if (a0 == 2'd0) b_test0 = 4'b0010;
      default: ;
    endcase
  end

  always @(posedge sys_clk) begin
    r1a     <= 8'd1 << a1;
    b_test1 <= r1a;
    r2a     <= 8'd1 << a2;
    b_test2 <= r2a;
  end

  decoder_quiz_checker #(.IN_W(2), .NUM_VEC(8), .LAT(0), .MODE(0)) u0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start0), .a(a0), .b_test(b_test0),
    .b_true(b_true0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_a(first_a0), .first_err_vld(vld0));

  decoder_quiz_checker #(.IN_W(3), .NUM_VEC(8), .LAT(2), .MODE(1), .SEED(16'hACE1)) u1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start1), .a(a1), .b_test(b_test1),
    .b_true(b_true1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_a(first_a1), .first_err_vld(vld1));

  decoder_quiz_checker #(.IN_W(3), .NUM_VEC(8), .LAT(1), .MODE(0)) u2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start2), .a(a2), .b_test(b_test2),
    .b_true(b_true2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .first_err_a(first_a2), .first_err_vld(vld2));

  decoder_quiz_checker #(.IN_W(2), .NUM_VEC(3), .LAT(0), .MODE(0)) u3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start3), .a(a3), .b_test(b_test3),
    .b_true(b_true3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .first_err_a(first_a3), .first_err_vld(vld3));

  typedef struct {
    int fault;
    int e_err;
    int e_pass;
    int e_first;
    int e_vld;
  } vec_t;

  vec_t       tbl [5];
  logic [2:0] exp_seq1 [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run0(input string tag, input int e_err, input int e_pass,
                      input int e_first, input int e_vld);
    start0 = 1'b1;
    @(negedge sys_clk);
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_a%0d", tag, k), a0, k % 4);
      check($sformatf("%s_busy%0d", tag, k), busy0, 1);
      @(negedge sys_clk);
    end
    check({tag, "_done"}, done0, 1);
    check({tag, "_busy_end"}, busy0, 0);
    check({tag, "_pass"}, pass0, e_pass);
    check({tag, "_err"}, err0, e_err);
    check({tag, "_vld"}, vld0, e_vld);
    if (e_vld != 0) check({tag, "_first_a"}, first_a0, e_first);
    repeat (2) @(negedge sys_clk);
    check({tag, "_done_hold"}, done0, 1);
    check({tag, "_err_hold"}, err0, e_err);
  endtask

  task automatic run1(input string tag, input bit poke);
    int cyc;
    start1 = 1'b1;
    @(negedge sys_clk);
    start1 = 1'b0;
    cyc = 0;
    while (busy1 && cyc < 40) begin
      if (cyc < 8) check($sformatf("%s_a%0d", tag, cyc), a1, exp_seq1[cyc]);
      else         check($sformatf("%s_a_hold%0d", tag, cyc), a1, exp_seq1[7]);
      start1 = (poke && cyc == 3);
      @(negedge sys_clk);
      cyc++;
    end
    start1 = 1'b0;
    check({tag, "_busy_cycles"}, cyc, 10);
    check({tag, "_done"}, done1, 1);
    check({tag, "_pass"}, pass1, 1);
    check({tag, "_err"}, err1, 0);
    check({tag, "_vld"}, vld1, 0);
  endtask

  initial begin
    logic [15:0] s;
    int cyc;

    tbl[0] = '{fault: 0, e_err: 0, e_pass: 1, e_first: 0, e_vld: 0};
    tbl[1] = '{fault: 1, e_err: 2, e_pass: 0, e_first: 2, e_vld: 1};
    tbl[2] = '{fault: 2, e_err: 8, e_pass: 0, e_first: 0, e_vld: 1};
    tbl[3] = '{fault: 3, e_err: 2, e_pass: 0, e_first: 3, e_vld: 1};
    tbl[4] = '{fault: 4, e_err: 2, e_pass: 0, e_first: 0, e_vld: 1};

    s = 16'hACE1;
    for (int k = 0; k < 8; k++) begin
      exp_seq1[k] = s[2:0];
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_a", a0, 0);
    check("rst_err", err0, 0);
    check("rst_first_a", first_a0, 0);
    check("rst_vld", vld0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_b_true", b_true0, 4'b0001);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("idle_no_start_busy", busy0, 0);

    // Pass and fault patterns, back-to-back runs restarted from DONE
    for (int i = 0; i < 5; i++) begin
      fault_sel = tbl[i].fault;
      run0($sformatf("tbl%0d", i), tbl[i].e_err, tbl[i].e_pass, tbl[i].e_first, tbl[i].e_vld);
    end

    // Reset in RUN cycle 5 with a faulty decoder, then a clean fresh run
    fault_sel = 2;
    start0 = 1'b1;
    @(negedge sys_clk);
    start0 = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("midrst_busy_before", busy0, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("midrst_busy", busy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_pass", pass0, 0);
    check("midrst_a", a0, 0);
    check("midrst_err", err0, 0);
    check("midrst_vld", vld0, 0);
    check("midrst_first_a", first_a0, 0);
    repeat (2) @(negedge sys_clk);
    check("midrst_stay_idle", busy0, 0);
    fault_sel = 0;
    run0("fresh", 0, 1, 0, 0);

    // LFSR sequence, LAT=2 drain, start ignored in RUN, identical rerun from DONE
    run1("lfsr_run1", 1'b1);
    repeat (3) @(negedge sys_clk);
    check("lfsr_done_hold", done1, 1);
    check("lfsr_busy_hold", busy1, 0);
    run1("lfsr_run2", 1'b0);

    // Latency one short of the decoder: vectors 1..7 mismatch
    start2 = 1'b1;
    @(negedge sys_clk);
    start2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 40) begin
      @(negedge sys_clk);
      cyc++;
    end
    check("lat1_busy_cycles", cyc, 9);
    check("lat1_done", done2, 1);
    check("lat1_err", err2, 7);
    check("lat1_pass", pass2, 0);
    check("lat1_vld", vld2, 1);
    check("lat1_first_a", first_a2, 1);

    // Saturation with NUM_VEC=3 and a stuck-at-zero decoder
    start3 = 1'b1;
    @(negedge sys_clk);
    start3 = 1'b0;
    cyc = 0;
    while (busy3 && cyc < 40) begin
      @(negedge sys_clk);
      cyc++;
    end
    check("sat_busy_cycles", cyc, 3);
    check("sat_done", done3, 1);
    check("sat_err", err3, 3);
    check("sat_pass", pass3, 0);
    check("sat_first_a", first_a3, 0);
    check("sat_a_hold", a3, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_quiz_checker.md
DECODER_QUIZ_CHECKER -- requirements
Module: decoder_quiz_checker

Interface
REQ-001 Parameter IN_W, default 2: decoder input width; output width OUT_W = 2**IN_W; legal 1..6.
REQ-002 Parameter NUM_VEC, default 64: vectors per run; legal 1..65535.
REQ-003 Parameter LAT, default 0: cycles from a change to the matching b_test; legal 0..3.
REQ-004 Parameter MODE, default 1: 0 = exhaustive sweep, 1 = LFSR random.
REQ-005 Parameter SEED, default 16'hACE1: LFSR start value; SEED=0 is replaced by 16'hACE1.
REQ-006 sys_clk  in  1  the only clock; all state updates on its rising edge.
REQ-007 sys_rst  in  1  reset, synchronous and active-high.
REQ-008 start  in  1  one-cycle request to begin a run.
REQ-009 a  out  IN_W  registered stimulus to the decoder under test.
REQ-010 b_test  in  OUT_W  decoder-under-test output.
REQ-011 b_true  out  OUT_W  reference decode of a, delayed LAT cycles; for observation.
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 done  out  1  high in DONE.
REQ-014 pass  out  1  high in DONE when err_cnt==0.
REQ-015 err_cnt  out  CNT_W=$clog2(NUM_VEC+1)  count of mismatching vectors.
REQ-016 first_err_a  out  IN_W  stimulus of the first mismatch; first_err_vld  out  1  valid flag for first_err_a.

Function
REQ-017 States: IDLE, RUN, DRAIN, DONE. Transitions: IDLE -start-> RUN; RUN -(NUM_VEC vectors issued)-> DRAIN, or -> DONE when LAT==0; DRAIN -(LAT cycles)-> DONE; DONE -start-> RUN.
REQ-018 On the RUN entry edge: a loads its first vector; err_cnt, first_err_vld and the vector counter clear; the LFSR reloads SEED.
REQ-019 In RUN, a advances once per cycle. MODE 0: 0,1,...,OUT_W-1, then wraps to 0. MODE 1: a = lfsr[IN_W-1:0], LFSR polynomial x^16+x^14+x^13+x^11+1, Fibonacci, shifting once per vector.
REQ-020 Vector k is on a in RUN cycle k. b_test is sampled at the end of cycle k+LAT and compared with one-hot(vector k) carried through a LAT-deep expected/valid pipeline.
REQ-021 A mismatch is any bit difference. Each mismatch increments err_cnt by 1, saturating at NUM_VEC. The first mismatch of a run captures first_err_a and sets first_err_vld.
REQ-022 Exactly NUM_VEC comparisons occur per run. Comparisons still in flight complete during DRAIN. No compare happens in IDLE or DONE.
REQ-023 start is ignored in RUN and DRAIN. start in DONE begins a new run on the next edge and clears the results.
REQ-024 done, pass, err_cnt, first_err_a and first_err_vld hold in DONE until the next start or reset.
REQ-025 a holds its last value outside RUN.

Reset
REQ-026 sys_rst is sampled on the sys_clk edge, from any state, including mid-run.
REQ-027 Reset state: FSM IDLE; a=0; err_cnt=0; first_err_a=0; first_err_vld=0; busy=done=pass=0; LFSR=SEED; expected/valid pipeline cleared.
REQ-028 No comparison is counted in the cycle reset is asserted or from in-flight pipeline contents.

Structure
REQ-029 Package decoder_quiz_pkg holds the state enum, the LFSR tap constant, and the default seed 16'hACE1.
REQ-030 One sub-module, line_decoder_ref (IN_W parameter, combinational one-hot decode), generates the expected value. Everything else is inline.

Verification
REQ-031 IN_W=2, LAT=0, MODE=0, NUM_VEC=8, correct decoder, start pulse -> a sequence 0,1,2,3,0,1,2,3; done after 8 cycles; pass=1; err_cnt=0.
REQ-032 Same setup, but the decoder maps a=2 to 4'b0000 -> err_cnt=2, pass=0, first_err_a=2'b10, first_err_vld=1.
REQ-033 IN_W=3, LAT=2, correct decoder with a 2-stage register -> busy for 10 cycles (8 RUN + 2 DRAIN); err_cnt=0; same decoder with LAT=1 gives err_cnt>0.
REQ-034 Reset asserted at RUN cycle 5 -> next cycle: IDLE, all outputs at reset values; a later start gives a full fresh run.
REQ-035 start pulsed during RUN, then pulsed in DONE -> first pulse has no effect; second pulse clears results and repeats the identical MODE 1 sequence from SEED.
REQ-036 IN_W=2, NUM_VEC=3, decoder outputs constant 0 -> err_cnt saturates at 3, no wrap.
